// File: rtl/race_official_multi_if.sv
// Bus bundle between the race official and the racer agents / sequencer.
// The official uses the slave view; the agents and the sequencer use the master view.
interface race_official_multi_if #(
  parameter int NUM_RACERS = 4,
  parameter int CNT_WIDTH  = 16
);
  localparam int WIN_W = (NUM_RACERS > 1) ? $clog2(NUM_RACERS) : 1;

  logic [NUM_RACERS-1:0] ready;
  logic [NUM_RACERS-1:0] done;
  logic                  start;
  logic                  result_valid;
  logic                  winner_valid;
  logic [WIN_W-1:0]      winner;
  logic [CNT_WIDTH-1:0]  winner_time;
  logic [NUM_RACERS-1:0] done_mask;
  logic                  timeout;

  modport master (
    output ready, done,
    input  start, result_valid, winner_valid, winner, winner_time, done_mask, timeout
  );

  modport slave (
    input  ready, done,
    output start, result_valid, winner_valid, winner, winner_time, done_mask, timeout
  );
endinterface

// File: rtl/race_official_multi.sv
// Multi-racer race official: arms when every racer is ready, times the race,
// records the first finisher and the finish set, and aborts on a timeout.
module race_official_multi #(
  parameter int NUM_RACERS = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  race_official_multi_if.slave    bus
);
  localparam int WIN_W = (NUM_RACERS > 1) ? $clog2(NUM_RACERS) : 1;
  localparam logic [63:0] TIMEOUT_LAST = 64'(TIMEOUT) - 64'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  cnt, cnt_next;
  logic [NUM_RACERS-1:0] mask, mask_next;
  logic                  wv, wv_next;
  logic [WIN_W-1:0]      win, win_next;
  logic [CNT_WIDTH-1:0]  wt, wt_next;
  logic                  to, to_next;
  logic                  rv, rv_next;

  logic [NUM_RACERS-1:0] new_done;
  logic [NUM_RACERS-1:0] seen;
  logic [WIN_W-1:0]      first_idx;
  logic [63:0]           cnt_wide;
  logic                  arm;
  logic                  quiet;
  logic                  timeout_hit;

  assign new_done    = bus.done & ~mask;
  assign seen        = mask | bus.done;
  assign arm         = (&bus.ready) && !(|bus.done);
  assign quiet       = !(|bus.ready) && !(|bus.done);
  assign cnt_wide    = 64'(cnt);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_wide == TIMEOUT_LAST);

  // Scanning downwards leaves the lowest newly finished index, which settles ties.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_RACERS - 1; i >= 0; i--) begin
      if (new_done[i]) first_idx = WIN_W'(i);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mask_next  = mask;
    wv_next    = wv;
    win_next   = win;
    wt_next    = wt;
    to_next    = to;
    rv_next    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_next = RUN;
          cnt_next   = '0;
          mask_next  = '0;
          wv_next    = 1'b0;
          win_next   = '0;
          wt_next    = '0;
          to_next    = 1'b0;
        end
      end
      RUN: begin
        cnt_next  = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_WIDTH'(1);
        mask_next = seen;
        if (!wv && (|new_done)) begin
          wv_next  = 1'b1;
          win_next = first_idx;
          wt_next  = cnt;
        end
        // Completion is tested first so a finish on the last allowed cycle is not a timeout.
        if (&seen) begin
          state_next = RELEASE;
          rv_next    = 1'b1;
        end else if (timeout_hit) begin
          state_next = RELEASE;
          rv_next    = 1'b1;
          to_next    = 1'b1;
        end
      end
      RELEASE: begin
        if (quiet) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mask  <= '0;
      wv    <= 1'b0;
      win   <= '0;
      wt    <= '0;
      to    <= 1'b0;
      rv    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      mask  <= mask_next;
      wv    <= wv_next;
      win   <= win_next;
      wt    <= wt_next;
      to    <= to_next;
      rv    <= rv_next;
    end
  end

  // start is high exactly while racing, so an illegal state code can never drive it.
  assign bus.start        = (state == RUN);
  assign bus.result_valid = rv;
  assign bus.winner_valid = wv;
  assign bus.winner       = win;
  assign bus.winner_time  = wt;
  assign bus.done_mask    = mask;
  assign bus.timeout      = to;
endmodule

// File: tb/tb_race_official_multi.sv
// Bench for race_official_multi: a fixed vector table, directed multi-cycle
// sequences and random traffic checked against a finish-time reference model.
module tb_race_official_multi;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] ready;
  logic [N-1:0] done;

  race_official_multi_if #(.NUM_RACERS(N), .CNT_WIDTH(16)) bus_a ();
  race_official_multi_if #(.NUM_RACERS(N), .CNT_WIDTH(4))  bus_b ();

  assign bus_a.ready = ready;
  assign bus_a.done  = done;
  assign bus_b.ready = ready;
  assign bus_b.done  = done;

  race_official_multi #(.NUM_RACERS(N), .CNT_WIDTH(16), .TIMEOUT(20)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  race_official_multi #(.NUM_RACERS(N), .CNT_WIDTH(4), .TIMEOUT(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic        use_b;
  logic        act_start, act_rv, act_wv, act_to;
  logic [1:0]  act_win;
  logic [15:0] act_wt;
  logic [3:0]  act_mask;

  always_comb begin
    act_start = bus_a.start;
    act_rv    = bus_a.result_valid;
    act_wv    = bus_a.winner_valid;
    act_win   = bus_a.winner;
    act_wt    = bus_a.winner_time;
    act_mask  = bus_a.done_mask;
    act_to    = bus_a.timeout;
    if (use_b) begin
      act_start = bus_b.start;
      act_rv    = bus_b.result_valid;
      act_wv    = bus_b.winner_valid;
      act_win   = bus_b.winner;
      act_wt    = 16'(bus_b.winner_time);
      act_mask  = bus_b.done_mask;
      act_to    = bus_b.timeout;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: remembers the race cycle at which each racer first
  // reported done and derives every result from those finish times.
  int       m_T;
  int       m_W;
  bit       m_racing;
  bit       m_draining;
  int       m_cycle;
  int       m_finish[N];
  bit       e_start, e_rv, e_wv, e_to;
  int       e_win, e_wt;
  logic [3:0] e_mask;

  task automatic clearResults();
    for (int i = 0; i < N; i++) m_finish[i] = -1;
    e_wv = 0; e_win = 0; e_wt = 0; e_mask = 4'h0; e_to = 0;
  endtask

  task automatic summarize();
    int best;
    int sat;
    best = -1;
    sat  = (1 << m_W) - 1;
    e_mask = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (m_finish[i] >= 0) begin
        e_mask[i] = 1'b1;
        if (best < 0 || m_finish[i] < m_finish[best]) best = i;
      end
    end
    e_wv  = (best >= 0);
    e_win = (best >= 0) ? best : 0;
    e_wt  = (best >= 0) ? ((m_finish[best] > sat) ? sat : m_finish[best]) : 0;
  endtask

  task automatic modelStep(input logic r, input logic [3:0] rd, input logic [3:0] dn);
    e_rv = 0;
    if (r) begin
      m_racing = 0;
      m_draining = 0;
      clearResults();
    end else if (m_racing) begin
      for (int i = 0; i < N; i++)
        if (dn[i] && m_finish[i] < 0) m_finish[i] = m_cycle;
      summarize();
      if (e_mask == 4'hF) begin
        m_racing = 0; m_draining = 1; e_rv = 1;
      end else if (m_T != 0 && m_cycle == m_T - 1) begin
        m_racing = 0; m_draining = 1; e_rv = 1; e_to = 1;
      end
      m_cycle++;
    end else if (m_draining) begin
      if (rd == 4'h0 && dn == 4'h0) m_draining = 0;
    end else if (rd == 4'hF && dn == 4'h0) begin
      m_racing = 1;
      m_cycle = 0;
      clearResults();
    end
    e_start = m_racing;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rd, input logic [3:0] dn);
    rst   = r;
    ready = rd;
    done  = dn;
    @(posedge clk);
    modelStep(r, rd, dn);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkField({tag, ".start"},        32'(act_start), 32'(e_start));
    checkField({tag, ".result_valid"}, 32'(act_rv),    32'(e_rv));
    checkField({tag, ".winner_valid"}, 32'(act_wv),    32'(e_wv));
    checkField({tag, ".winner"},       32'(act_win),   32'(e_win));
    checkField({tag, ".winner_time"},  32'(act_wt),    32'(e_wt));
    checkField({tag, ".done_mask"},    32'(act_mask),  32'(e_mask));
    checkField({tag, ".timeout"},      32'(act_to),    32'(e_to));
  endtask

  task automatic stepCheck(input string tag, input logic r, input logic [3:0] rd, input logic [3:0] dn);
    applyStimulus(r, rd, dn);
    checkOutput(tag);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rdy;
    logic [3:0]  dn;
    logic        s;
    logic        rv;
    logic        wv;
    logic [1:0]  win;
    logic [15:0] wt;
    logic [3:0]  mask;
    logic        to;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic [3:0] rd, input logic [3:0] dn,
                        input logic s, input logic rv, input logic wv, input logic [1:0] win,
                        input logic [15:0] wt, input logic [3:0] mask, input logic to);
    vec_t v;
    v.rst = r; v.rdy = rd; v.dn = dn; v.s = s; v.rv = rv; v.wv = wv;
    v.win = win; v.wt = wt; v.mask = mask; v.to = to;
    vecs.push_back(v);
  endtask

  initial begin
    int hi;
    logic       rr;
    logic [3:0] rd, dn;

    use_b = 1'b0;
    m_T = 20;
    m_W = 16;
    m_racing = 0;
    m_draining = 0;
    m_cycle = 0;
    clearResults();
    e_start = 0;
    e_rv = 0;

    // rst rdy dn | start rv wv win wt mask to
    addVec(1, 4'h0, 4'h0,  0, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'hF, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'hF, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'hF, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'hF, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'hF, 4'h4,  1, 0, 1, 2, 3, 4'h4, 0);
    addVec(0, 4'hF, 4'h4,  1, 0, 1, 2, 3, 4'h4, 0);
    addVec(0, 4'hF, 4'h5,  1, 0, 1, 2, 3, 4'h5, 0);
    addVec(0, 4'hF, 4'h7,  1, 0, 1, 2, 3, 4'h7, 0);
    addVec(0, 4'hF, 4'h7,  1, 0, 1, 2, 3, 4'h7, 0);
    addVec(0, 4'hF, 4'h7,  1, 0, 1, 2, 3, 4'h7, 0);
    addVec(0, 4'hF, 4'hF,  0, 1, 1, 2, 3, 4'hF, 0);
    addVec(0, 4'hF, 4'hF,  0, 0, 1, 2, 3, 4'hF, 0);
    addVec(0, 4'h1, 4'h0,  0, 0, 1, 2, 3, 4'hF, 0);
    addVec(0, 4'hF, 4'h0,  0, 0, 1, 2, 3, 4'hF, 0);
    addVec(0, 4'h0, 4'h0,  0, 0, 1, 2, 3, 4'hF, 0);
    addVec(0, 4'hF, 4'h2,  0, 0, 1, 2, 3, 4'hF, 0);
    addVec(0, 4'hF, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'h0, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'h0, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'h0, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'h0, 4'h0,  1, 0, 0, 0, 0, 4'h0, 0);
    addVec(0, 4'h0, 4'hA,  1, 0, 1, 1, 4, 4'hA, 0);
    addVec(0, 4'h0, 4'hA,  1, 0, 1, 1, 4, 4'hA, 0);
    addVec(0, 4'h0, 4'hA,  1, 0, 1, 1, 4, 4'hA, 0);
    addVec(0, 4'h0, 4'hF,  0, 1, 1, 1, 4, 4'hF, 0);
    addVec(0, 4'h0, 4'h0,  0, 0, 1, 1, 4, 4'hF, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].dn);
      checkField($sformatf("vec%0d.start", i),        32'(act_start), 32'(vecs[i].s));
      checkField($sformatf("vec%0d.result_valid", i), 32'(act_rv),    32'(vecs[i].rv));
      checkField($sformatf("vec%0d.winner_valid", i), 32'(act_wv),    32'(vecs[i].wv));
      checkField($sformatf("vec%0d.winner", i),       32'(act_win),   32'(vecs[i].win));
      checkField($sformatf("vec%0d.winner_time", i),  32'(act_wt),    32'(vecs[i].wt));
      checkField($sformatf("vec%0d.done_mask", i),    32'(act_mask),  32'(vecs[i].mask));
      checkField($sformatf("vec%0d.timeout", i),      32'(act_to),    32'(vecs[i].to));
    end

    // Timeout with a single finisher: start must stay high for exactly 20 cycles.
    stepCheck("to1.arm", 0, 4'hF, 4'h0);
    hi = int'(act_start);
    for (int k = 0; k < 20; k++) begin
      stepCheck($sformatf("to1.c%0d", k), 0, 4'hF, (k >= 2) ? 4'h8 : 4'h0);
      hi += int'(act_start);
    end
    checkField("to1.start_cycles", 32'(hi), 32'd20);
    checkField("to1.timeout",      32'(act_to),   32'd1);
    checkField("to1.done_mask",    32'(act_mask), 32'h8);
    checkField("to1.winner",       32'(act_win),  32'd3);
    checkField("to1.winner_valid", 32'(act_wv),   32'd1);
    stepCheck("to1.rel", 0, 4'h0, 4'h0);

    // Timeout with nobody finishing.
    stepCheck("to0.arm", 0, 4'hF, 4'h0);
    for (int k = 0; k < 20; k++) stepCheck($sformatf("to0.c%0d", k), 0, 4'hF, 4'h0);
    checkField("to0.winner_valid", 32'(act_wv), 32'd0);
    checkField("to0.timeout",      32'(act_to), 32'd1);
    stepCheck("to0.rel", 0, 4'h0, 4'h0);

    // Completion on the last allowed cycle is not a timeout.
    stepCheck("edge.arm", 0, 4'hF, 4'h0);
    for (int k = 0; k < 20; k++)
      stepCheck($sformatf("edge.c%0d", k), 0, 4'hF, (k == 19) ? 4'hF : ((k >= 10) ? 4'h1 : 4'h0));
    checkField("edge.timeout",      32'(act_to),   32'd0);
    checkField("edge.result_valid", 32'(act_rv),   32'd1);
    checkField("edge.winner_time",  32'(act_wt),   32'd10);
    stepCheck("edge.rel", 0, 4'h0, 4'h0);

    // Reset in the middle of a race, then a fresh race.
    stepCheck("rst.arm", 0, 4'hF, 4'h0);
    for (int k = 0; k < 5; k++) stepCheck($sformatf("rst.c%0d", k), 0, 4'hF, (k >= 1) ? 4'h2 : 4'h0);
    stepCheck("rst.hit", 1, 4'hF, 4'h2);
    checkField("rst.start",        32'(act_start), 32'd0);
    checkField("rst.winner_valid", 32'(act_wv),    32'd0);
    checkField("rst.done_mask",    32'(act_mask),  32'd0);
    stepCheck("rst.arm2", 0, 4'hF, 4'h0);
    for (int k = 0; k < 5; k++)
      stepCheck($sformatf("rst.r%0d", k), 0, 4'hF, (k == 4) ? 4'hF : ((k == 3) ? 4'h6 : 4'h0));
    checkField("rst.winner",      32'(act_win), 32'd1);
    checkField("rst.winner_time", 32'(act_wt),  32'd3);
    stepCheck("rst.rel", 0, 4'h0, 4'h0);

    for (int c = 0; c < 2000; c++) begin
      rr = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 9))
        0, 1, 2: begin rd = 4'hF; dn = 4'h0; end
        3, 4:    begin rd = 4'h0; dn = 4'h0; end
        default: begin
          rd = 4'($urandom);
          dn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        end
      endcase
      stepCheck($sformatf("rndA%0d", c), rr, rd, dn);
    end

    // Narrow counter, timeout disabled: the counter saturates and no timeout fires.
    use_b = 1'b1;
    m_T = 0;
    m_W = 4;
    stepCheck("sat.rst", 1, 4'h0, 4'h0);
    stepCheck("sat.arm", 0, 4'hF, 4'h0);
    hi = int'(act_start);
    for (int k = 0; k < 30; k++) begin
      stepCheck($sformatf("sat.c%0d", k), 0, 4'hF, (k == 29) ? 4'hF : ((k >= 20) ? 4'h1 : 4'h0));
      hi += int'(act_start);
    end
    checkField("sat.start_cycles", 32'(hi),     32'd30);
    checkField("sat.winner_time",  32'(act_wt), 32'd15);
    checkField("sat.timeout",      32'(act_to), 32'd0);
    stepCheck("sat.rel", 0, 4'h0, 4'h0);

    for (int c = 0; c < 1500; c++) begin
      rr = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 9))
        0, 1, 2: begin rd = 4'hF; dn = 4'h0; end
        3, 4:    begin rd = 4'h0; dn = 4'h0; end
        default: begin
          rd = 4'($urandom);
          dn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        end
      endcase
      stepCheck($sformatf("rndB%0d", c), rr, rd, dn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
